// File: rtl/sum_cla_multiciclo.sv
// Multi-cycle carry-lookahead adder: one BLOCK-bit CLA slice per clock, LSB first.
// Optional subtract mode (A - B) is enabled by defining SUM_CLA_SUB_EN.
module sum_cla_multiciclo #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
`ifdef SUM_CLA_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NBLK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] b_ld;
    logic             c_ld;

`ifdef SUM_CLA_SUB_EN
    // Two's complement subtract: invert B and force the initial carry.
    assign b_ld = sub ? ~B : B;
    assign c_ld = sub ? 1'b1 : cin;
`else
    assign b_ld = B;
    assign c_ld = cin;
`endif

    int               base;
    logic [BLOCK-1:0] a_s;
    logic [BLOCK-1:0] b_s;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   cy;
    logic [BLOCK-1:0] s;
    logic             acc;
    logic             term;

    // Each carry is a flat sum of generate terms gated by the propagate chain.
    always_comb begin
        base = int'(k_q) * BLOCK;
        a_s  = a_q[base +: BLOCK];
        b_s  = b_q[base +: BLOCK];
        g    = a_s & b_s;
        p    = a_s ^ b_s;
        cy   = '0;
        acc  = 1'b0;
        term = 1'b0;
        cy[0] = c_q;
        for (int i = 0; i < BLOCK; i++) begin
            acc  = g[i];
            term = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (term & g[j]);
                term = term & p[j];
            end
            cy[i+1] = acc | (term & c_q);
        end
        s = p ^ cy[BLOCK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= b_ld;
                        c_q     <= c_ld;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[base +: BLOCK] <= s;
                    c_q <= cy[BLOCK];
                    if (k_q == KLAST) begin
                        cout_q  <= cy[BLOCK];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
